// File: rtl/fdiv_param.sv
// Parameterised IEEE-style floating-point divider, restoring, one quotient bit per cycle.
// Latency: done pulses MAN_W+6 edges after the accept edge for every operand class.
// Backpressure: none; dispatch is taken only while idle, and a dispatch while busy is dropped.
module fdiv_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dispatch,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [1:0]           op,
    output logic [EXP_W+MAN_W:0] q,
    output logic                 done,
    output logic                 busy,
    output logic [4:0]           flags
);

    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int EW2     = EXP_W + 2;
    localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int EXP_MAX = (1 << EXP_W) - 1;
    localparam int CNT_W   = $clog2(MAN_W + 3);

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, PACK} state_t;

    state_t             state, state_n;
    logic [W-1:0]       ra, rb;
    logic [1:0]         rop;
    logic               sign;
    logic [EW2-1:0]     exp_q;
    logic [MAN_W:0]     mb;
    logic [MAN_W+1:0]   rem;
    logic [MAN_W+2:0]   quo;
    logic [CNT_W-1:0]   cnt;
    logic               spec;
    logic [W-1:0]       spec_q;
    logic [4:0]         spec_f;
    logic [EW2-1:0]     rexp;
    logic [MAN_W-1:0]   rfrac;
    logic               rinexact;

    assign busy = (state != IDLE);

    // Operand classification and special-case results
    logic               sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               spec_c;
    logic [W-1:0]       spec_q_c;
    logic [4:0]         spec_f_c;
    logic [EW2-1:0]     exp_c;

    always_comb begin
        sa       = ra[W-1];
        sb       = rb[W-1];
        ea       = ra[W-2:MAN_W];
        eb       = rb[W-2:MAN_W];
        fa       = ra[MAN_W-1:0];
        fb       = rb[MAN_W-1:0];
        a_zero   = (ea == '0);
        b_zero   = (eb == '0);
        a_nan    = (&ea) && (|fa);
        b_nan    = (&eb) && (|fb);
        a_inf    = (&ea) && !(|fa);
        b_inf    = (&eb) && !(|fb);
        exp_c    = EW2'(ea) - EW2'(eb) + EW2'(BIAS);
        spec_c   = 1'b1;
        spec_q_c = '0;
        spec_f_c = '0;
        if (a_nan) begin
            spec_q_c = {sa, ea, 1'b1, fa[MAN_W-2:0]};
            spec_f_c = {~fa[MAN_W-1], 4'b0000};
        end else if (b_nan) begin
            spec_q_c = {sb, eb, 1'b1, fb[MAN_W-2:0]};
            spec_f_c = {~fb[MAN_W-1], 4'b0000};
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_q_c = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            spec_f_c = 5'b10000;
        end else if (a_inf) begin
            spec_q_c = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf || a_zero) begin
            spec_q_c = {sa ^ sb, {(W-1){1'b0}}};
        end else if (b_zero) begin
            spec_q_c = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_f_c = 5'b01000;
        end else begin
            spec_c = 1'b0;
        end
    end

    // Restoring divide step
    logic             ge;
    logic [MAN_W+1:0] rem_sub;
    logic [MAN_W+1:0] rem_nxt;

    always_comb begin
        ge      = (rem >= {1'b0, mb});
        rem_sub = ge ? (rem - {1'b0, mb}) : rem;
        rem_nxt = {rem_sub[MAN_W:0], 1'b0};
    end

    // Normalise then round; the quotient holds one spare bit for the normalising shift
    logic [MAN_W:0]   mant;
    logic             g, s, inc;
    logic [EW2-1:0]   e_n, exp_r;
    logic [MAN_W+1:0] sum;
    logic [MAN_W-1:0] frac_r;

    always_comb begin
        if (quo[MAN_W+2]) begin
            mant = quo[MAN_W+2:2];
            g    = quo[1];
            s    = quo[0] | (|rem);
            e_n  = exp_q;
        end else begin
            mant = quo[MAN_W+1:1];
            g    = quo[0];
            s    = |rem;
            e_n  = exp_q - EW2'(1);
        end
        case (rop)
            2'b00:   inc = g & (s | mant[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = ~sign & (g | s);
            default: inc = sign & (g | s);
        endcase
        sum = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
        if (sum[MAN_W+1]) begin
            frac_r = sum[MAN_W:1];
            exp_r  = e_n + EW2'(1);
        end else begin
            frac_r = sum[MAN_W-1:0];
            exp_r  = e_n;
        end
    end

    // Final packing with overflow/underflow handling
    logic         ovf, unf;
    logic [W-1:0] inf_w, max_w, q_c;
    logic [4:0]   flags_c;

    always_comb begin
        ovf     = !rexp[EW2-1] && (rexp >= EW2'(EXP_MAX));
        unf     = rexp[EW2-1] || (rexp == '0);
        inf_w   = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        max_w   = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        q_c     = {sign, rexp[EXP_W-1:0], rfrac};
        flags_c = {4'b0000, rinexact};
        if (spec) begin
            q_c     = spec_q;
            flags_c = spec_f;
        end else if (ovf) begin
            case (rop)
                2'b00:   q_c = inf_w;
                2'b01:   q_c = max_w;
                2'b10:   q_c = sign ? max_w : inf_w;
                default: q_c = sign ? inf_w : max_w;
            endcase
            flags_c = 5'b00101;
        end else if (unf) begin
            q_c     = {sign, {(W-1){1'b0}}};
            flags_c = 5'b00011;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (dispatch) state_n = UNPACK;
            UNPACK:  state_n = DIVIDE;
            DIVIDE:  if (cnt == CNT_W'(MAN_W + 2)) state_n = ROUND;
            ROUND:   state_n = PACK;
            PACK:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            flags <= '0;
            done  <= 1'b0;
        end else begin
            done <= (state == PACK);
            case (state)
                IDLE: if (dispatch) begin
                    ra  <= a;
                    rb  <= b;
                    rop <= op;
                end
                UNPACK: begin
                    sign   <= sa ^ sb;
                    exp_q  <= exp_c;
                    mb     <= {1'b1, fb};
                    rem    <= {1'b0, 1'b1, fa};
                    quo    <= '0;
                    cnt    <= '0;
                    spec   <= spec_c;
                    spec_q <= spec_q_c;
                    spec_f <= spec_f_c;
                end
                DIVIDE: begin
                    rem <= rem_nxt;
                    quo <= {quo[MAN_W+1:0], ge};
                    cnt <= cnt + CNT_W'(1);
                end
                ROUND: begin
                    rexp     <= exp_r;
                    rfrac    <= frac_r;
                    rinexact <= g | s;
                end
                PACK: begin
                    q     <= q_c;
                    flags <= flags_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_param.sv
// Directed bench for fdiv_param: default single-precision instance plus a half-precision instance.
module tb_fdiv_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp0, disp1;
    logic [31:0] a0, b0, q0;
    logic [15:0] a1, b1, q1;
    logic [1:0]  op0, op1;
    logic        done0, busy0, done1, busy1;
    logic [4:0]  flags0, flags1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fdiv_param u0 (
        .clk(clk), .rst(rst), .dispatch(disp0), .a(a0), .b(b0), .op(op0),
        .q(q0), .done(done0), .busy(busy0), .flags(flags0)
    );

    fdiv_param #(.EXP_W(5), .MAN_W(10)) u1 (
        .clk(clk), .rst(rst), .dispatch(disp1), .a(a1), .b(b1), .op(op1),
        .q(q1), .done(done1), .busy(busy1), .flags(flags1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Returns the number of edges after the accept edge at which done was seen (-1 on timeout)
    task automatic wait_done0(input int start, output int lat);
        lat = -1;
        for (int i = start; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done0) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run0(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] top,
                        output logic [31:0] rq, output logic [4:0] rf, output int lat);
        @(negedge clk);
        a0 = ta; b0 = tb; op0 = top; disp0 = 1'b1;
        @(posedge clk); #1;
        disp0 = 1'b0;
        chk("busy_after_accept", busy0, 1'b1);
        wait_done0(1, lat);
        rq = q0;
        rf = flags0;
    endtask

    task automatic no_done0(input int n, input string tag);
        int seen = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done0) seen++;
        end
        chk(tag, seen, 0);
    endtask

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] q;
        logic [4:0]  f;
        logic        chk_f;
    } vec_t;

    vec_t vecs[] = '{
        '{"one_over_half",   32'h3f800000, 32'h3f000000, 2'b00, 32'h40000000, 5'b00000, 1'b1},
        '{"pi_over_e",       32'h40490fdb, 32'h402df854, 2'b00, 32'h3f93eee0, 5'b00000, 1'b0},
        '{"e_over_pi",       32'h402df854, 32'h40490fdb, 2'b00, 32'h3f5d816a, 5'b00000, 1'b0},
        '{"one_over_near2",  32'h3f800000, 32'h3fffffff, 2'b00, 32'h3f000001, 5'b00001, 1'b1},
        '{"third_rne",       32'h3f800000, 32'h40400000, 2'b00, 32'h3eaaaaab, 5'b00001, 1'b1},
        '{"third_rtz",       32'h3f800000, 32'h40400000, 2'b01, 32'h3eaaaaaa, 5'b00001, 1'b1},
        '{"third_rup",       32'h3f800000, 32'h40400000, 2'b10, 32'h3eaaaaab, 5'b00001, 1'b1},
        '{"third_rdn",       32'h3f800000, 32'h40400000, 2'b11, 32'h3eaaaaaa, 5'b00001, 1'b1},
        '{"neg_third_rdn",   32'hbf800000, 32'h40400000, 2'b11, 32'hbeaaaaab, 5'b00001, 1'b1},
        '{"div_by_zero",     32'h3f800000, 32'h00000000, 2'b00, 32'h7f800000, 5'b01000, 1'b1},
        '{"zero_over_zero",  32'h00000000, 32'h00000000, 2'b00, 32'hffc00000, 5'b10000, 1'b1},
        '{"qnan_a",          32'hffffface, 32'h3f800000, 2'b00, 32'hffffface, 5'b00000, 1'b1},
        '{"snan_a",          32'h7f800001, 32'h3f800000, 2'b00, 32'h7fc00001, 5'b10000, 1'b1},
        '{"snan_b",          32'h3f800000, 32'hff800005, 2'b00, 32'hffc00005, 5'b10000, 1'b1},
        '{"inf_over_inf",    32'h7f800000, 32'hff800000, 2'b00, 32'hffc00000, 5'b10000, 1'b1},
        '{"inf_over_neg1",   32'h7f800000, 32'hbf800000, 2'b00, 32'hff800000, 5'b00000, 1'b1},
        '{"one_over_inf",    32'h3f800000, 32'h7f800000, 2'b00, 32'h00000000, 5'b00000, 1'b1},
        '{"subn_over_one",   32'h00000001, 32'h3f800000, 2'b00, 32'h00000000, 5'b00000, 1'b1},
        '{"one_over_nsubn",  32'h3f800000, 32'h80000001, 2'b00, 32'hff800000, 5'b01000, 1'b1},
        '{"ovf_rne",         32'h7f000000, 32'h00800000, 2'b00, 32'h7f800000, 5'b00101, 1'b1},
        '{"ovf_rtz",         32'h7f000000, 32'h00800000, 2'b01, 32'h7f7fffff, 5'b00101, 1'b1},
        '{"ovf_neg_rup",     32'hff000000, 32'h00800000, 2'b10, 32'hff7fffff, 5'b00101, 1'b1},
        '{"ovf_neg_rdn",     32'hff000000, 32'h00800000, 2'b11, 32'hff800000, 5'b00101, 1'b1},
        '{"underflow",       32'h80800000, 32'h7f000000, 2'b00, 32'h80000000, 5'b00011, 1'b1}
    };

    initial begin
        logic [31:0] rq;
        logic [4:0]  rf;
        int          lat;

        rst = 1'b1; disp0 = 1'b0; disp1 = 1'b0;
        a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state0", {q0, flags0, busy0, done0}, 39'd0);
        chk("reset_state1", {q1, flags1, busy1, done1}, 23'd0);
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i]) begin
            run0(vecs[i].a, vecs[i].b, vecs[i].op, rq, rf, lat);
            chk({vecs[i].tag, "_q"}, rq, vecs[i].q);
            if (vecs[i].chk_f) chk({vecs[i].tag, "_flags"}, rf, vecs[i].f);
            chk({vecs[i].tag, "_lat"}, lat, 29);
            chk({vecs[i].tag, "_busy_at_done"}, busy0, 1'b0);
        end

        // Back-to-back: accept on the very edge where done is high
        @(negedge clk);
        a0 = 32'h3f800000; b0 = 32'h3f000000; op0 = 2'b00; disp0 = 1'b1;
        @(posedge clk); #1;
        wait_done0(1, lat);
        a0 = 32'h3f800000; b0 = 32'h40400000;
        @(posedge clk); #1;
        disp0 = 1'b0;
        chk("b2b_first_q", q0, 32'h40000000);
        chk("b2b_second_busy", busy0, 1'b1);
        wait_done0(1, lat);
        chk("b2b_second_q", q0, 32'h3eaaaaab);
        chk("b2b_second_lat", lat, 29);

        // Dispatch while busy is ignored
        @(negedge clk);
        a0 = 32'h3f800000; b0 = 32'h40400000; op0 = 2'b01; disp0 = 1'b1;
        @(posedge clk); #1;
        disp0 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        a0 = 32'h00000000; b0 = 32'h00000000; op0 = 2'b00; disp0 = 1'b1;
        @(posedge clk); #1;
        disp0 = 1'b0;
        wait_done0(6, lat);
        chk("busy_dispatch_q", q0, 32'h3eaaaaaa);
        chk("busy_dispatch_lat", lat, 29);
        no_done0(40, "busy_dispatch_no_extra_done");

        // Reset mid-operation at accept+10
        @(negedge clk);
        a0 = 32'h3f800000; b0 = 32'h3f000000; op0 = 2'b00; disp0 = 1'b1;
        @(posedge clk); #1;
        disp0 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_outputs", {q0, flags0, busy0, done0}, 39'd0);
        @(negedge clk); rst = 1'b0;
        no_done0(40, "midreset_no_done");
        run0(32'h40490fdb, 32'h402df854, 2'b00, rq, rf, lat);
        chk("after_reset_q", rq, 32'h3f93eee0);
        chk("after_reset_lat", lat, 29);

        // Reset wins over a dispatch on the same edge
        @(negedge clk);
        rst = 1'b1; disp0 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; disp0 = 1'b0;
        chk("rst_vs_dispatch_busy", busy0, 1'b0);
        no_done0(40, "rst_vs_dispatch_no_done");

        // Half-precision instance: 1.0 / 2.0
        @(negedge clk);
        a1 = 16'h3c00; b1 = 16'h4000; op1 = 2'b00; disp1 = 1'b1;
        @(posedge clk); #1;
        disp1 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done1) begin
                lat = i;
                break;
            end
        end
        chk("half_q", q1, 16'h3800);
        chk("half_flags", flags1, 5'b00000);
        chk("half_lat", lat, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
